// File: rtl/uart_8250_tx.sv
// 8250-compatible UART transmit engine: pops bytes from the TX FIFO
// and serialises them with LCR framing and 16x divisor-latch timing.
`timescale 1ns/1ps
module uart_8250_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [15:0] divisor_i,
    input  logic [7:0]  lcr_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        txd_o,
    output logic        tx_busy_o
);

    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_1P5  = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_2    = TW'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_n;
    logic [15:0]   presc_q, presc_n;
    logic [TW-1:0] tick_q, tick_n;
    logic [2:0]    bidx_q, bidx_n;
    logic [7:0]    shreg_q, shreg_n;
    logic [3:0]    lcr_q, lcr_n;
    logic [15:0]   div_q, div_n;
    logic          par_q, par_n;
    logic          txd_q, txd_n;
    logic          rdy_en_q;

    logic          accept;
    logic          tick;
    logic          bit_end;
    logic          lvl;
    logic [TW-1:0] last_tick;
    logic [2:0]    last_bit;
    logic [7:0]    mask;
    logic          xr;
    logic          unused_dlab;

    assign unused_dlab = lcr_i[7];

    assign tx_ready_o = (state_q == S_IDLE) && rdy_en_q;
    assign tx_busy_o  = (state_q != S_IDLE);
    assign txd_o      = txd_q;
    assign accept     = tx_valid_i && tx_ready_o;

    assign last_bit = 3'd4 + {1'b0, lcr_q[1:0]};
    assign mask     = 8'hFF >> (2'd3 - lcr_i[1:0]);
    assign xr       = ^(tx_data_i & mask);

    always_comb begin
        last_tick = T_BIT;
        if (state_q == S_STOP && lcr_q[2]) begin
            last_tick = (lcr_q[1:0] == 2'b00) ? T_1P5 : T_2;
        end
    end

    always_comb begin
        state_n = state_q;
        presc_n = presc_q;
        tick_n  = tick_q;
        bidx_n  = bidx_q;
        shreg_n = shreg_q;
        lcr_n   = lcr_q;
        div_n   = div_q;
        par_n   = par_q;
        tick    = 1'b0;
        bit_end = 1'b0;
        lvl     = 1'b1;

        if (state_q == S_IDLE) begin
            if (accept) begin
                state_n = S_START;
                shreg_n = tx_data_i;
                lcr_n   = lcr_i[3:0];
                div_n   = (divisor_i == 16'd0) ? 16'd1 : divisor_i;
                presc_n = '0;
                tick_n  = '0;
                bidx_n  = '0;
                // parity resolved now so stick/even/odd need not be kept
                par_n   = lcr_i[5] ? ~lcr_i[4] : ~(lcr_i[4] ^ xr);
            end
        end else begin
            if (presc_q == div_q - 16'd1) begin
                presc_n = '0;
                tick    = 1'b1;
            end else begin
                presc_n = presc_q + 16'd1;
            end
            if (tick) begin
                if (tick_q == last_tick) begin
                    tick_n  = '0;
                    bit_end = 1'b1;
                end else begin
                    tick_n = tick_q + TW'(1);
                end
            end
        end

        if (bit_end) begin
            unique case (state_q)
                S_START: begin
                    state_n = S_DATA;
                    bidx_n  = '0;
                end
                S_DATA: begin
                    if (bidx_q == last_bit) begin
                        state_n = lcr_q[3] ? S_PARITY : S_STOP;
                    end else begin
                        bidx_n  = bidx_q + 3'd1;
                        shreg_n = shreg_q >> 1;
                    end
                end
                S_PARITY: state_n = S_STOP;
                S_STOP:   state_n = S_IDLE;
                default:  state_n = S_IDLE;
            endcase
        end

        unique case (state_n)
            S_START:  lvl = 1'b0;
            S_DATA:   lvl = shreg_n[0];
            S_PARITY: lvl = par_n;
            default:  lvl = 1'b1;
        endcase
    end

    // break is live: it masks the line without touching frame timing
    assign txd_n = ~lcr_i[6] & lvl;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            tick_q   <= '0;
            bidx_q   <= '0;
            shreg_q  <= '0;
            lcr_q    <= '0;
            div_q    <= '0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            presc_q  <= presc_n;
            tick_q   <= tick_n;
            bidx_q   <= bidx_n;
            shreg_q  <= shreg_n;
            lcr_q    <= lcr_n;
            div_q    <= div_n;
            par_q    <= par_n;
            txd_q    <= txd_n;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_8250_tx.sv
// Randomised self-checking bench for uart_8250_tx against a
// per-cycle waveform model built from the frame rules.
`timescale 1ns/1ps
module tb_uart_8250_tx;

    logic        clk;
    logic        rst_n;
    logic [15:0] divisor_i;
    logic [7:0]  lcr_i;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic        txd_o;
    logic        tx_busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    uart_8250_tx dut (
        .CLK_I      (clk),
        .RST_I      (rst_n),
        .divisor_i  (divisor_i),
        .lcr_i      (lcr_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .txd_o      (txd_o),
        .tx_busy_o  (tx_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected txd per cycle after accept; cycles after brk_from read 0
    function automatic int model(input logic [7:0] data, input logic [7:0] lcr,
                                 input int d, input int brk_from,
                                 output logic [2047:0] w);
        int dp, n, ones, len, stop;
        int lv[$];
        int tk[$];
        dp = (d == 0) ? 1 : d;
        n = 5 + int'(lcr[1:0]);
        ones = 0;
        lv.push_back(0); tk.push_back(16);
        for (int i = 0; i < n; i++) begin
            lv.push_back(int'(data[i])); tk.push_back(16);
            ones += int'(data[i]);
        end
        if (lcr[3]) begin
            if (lcr[5]) lv.push_back(lcr[4] ? 0 : 1);
            else if (lcr[4]) lv.push_back(ones % 2);
            else lv.push_back(1 - ones % 2);
            tk.push_back(16);
        end
        stop = !lcr[2] ? 16 : (n == 5 ? 24 : 32);
        lv.push_back(1); tk.push_back(stop);
        w = '0;
        len = 0;
        for (int b = 0; b < lv.size(); b++) begin
            for (int k = 0; k < tk[b] * dp; k++) begin
                w[len] = (brk_from >= 0 && len > brk_from) ? 1'b0 : lv[b][0];
                len++;
            end
        end
        return len;
    endfunction

    task automatic start_frame(input logic [7:0] data, input bit hold);
        int c;
        c = 0;
        while (!tx_ready_o && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (!tx_ready_o) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: got tx_ready_o=0 required 1");
        end
        tx_data_i = data;
        tx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_valid_i = 1'b0;
    endtask

    // records txd per cycle until busy drops, plus the first idle cycle
    task automatic capture(input int chg_at, input logic [15:0] chg_div,
                           input logic [7:0] chg_lcr, output int len,
                           output logic [2047:0] w, output logic rdy_low,
                           output logic idle_rdy, output logic idle_txd);
        len = 0; w = '0; rdy_low = 1'b1;
        idle_rdy = 1'b0; idle_txd = 1'bx;
        for (int c = 0; c < 2048; c++) begin
            @(negedge clk);
            if (!tx_busy_o) begin
                idle_rdy = tx_ready_o;
                idle_txd = txd_o;
                break;
            end
            w[len] = txd_o;
            if (tx_ready_o) rdy_low = 1'b0;
            if (c == chg_at) begin
                divisor_i = chg_div;
                lcr_i = chg_lcr;
            end
            len++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tx_valid_i = 1'b0; tx_data_i = '0;
        divisor_i = 16'd1; lcr_i = 8'h03;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({txd_o, tx_ready_o, tx_busy_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_state: got txd/rdy/busy=%b required 100",
                     {txd_o, tx_ready_o, tx_busy_o});
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (tx_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL release_ready: got %b required 0", tx_ready_o);
        end
        @(negedge clk);
        n_cmp++;
        if ({txd_o, tx_ready_o, tx_busy_o} !== 3'b110) begin
            n_bad++;
            $display("FAIL post_reset: got txd/rdy/busy=%b required 110",
                     {txd_o, tx_ready_o, tx_busy_o});
        end
    endtask

    task automatic test_formats;
        logic [7:0]  tdat[8] = '{8'h55, 8'h07, 8'h07, 8'h07, 8'h1F, 8'h1F, 8'h1F, 8'hC3};
        logic [7:0]  tlcr[8] = '{8'h03, 8'h1B, 8'h0B, 8'h3B, 8'h04, 8'h04, 8'h07, 8'h2E};
        int          tdiv[8] = '{1, 3, 3, 3, 0, 1, 1, 2};
        int len, elen;
        logic [2047:0] w, ew;
        logic rl, ir, it;
        for (int t = 0; t < 8; t++) begin
            divisor_i = 16'(tdiv[t]);
            lcr_i = tlcr[t];
            start_frame(tdat[t], 1'b0);
            capture(-1, '0, '0, len, w, rl, ir, it);
            elen = model(tdat[t], tlcr[t], tdiv[t], -1, ew);
            n_cmp++;
            if (len !== elen || w !== ew) begin
                n_bad++;
                $display("FAIL fmt%0d_wave: got %0d cycles (%0d differ) required %0d",
                         t, len, $countones(w ^ ew), elen);
            end
            n_cmp++;
            if ({rl, ir, it} !== 3'b111) begin
                n_bad++;
                $display("FAIL fmt%0d_handshake: got rdylow/idlerdy/idletxd=%b required 111",
                         t, {rl, ir, it});
            end
        end
    endtask

    task automatic test_back_to_back;
        int len, elen;
        logic [2047:0] w, ew;
        logic rl, ir, it;
        divisor_i = 16'd1;
        lcr_i = 8'h03;
        start_frame(8'hA5, 1'b1);
        tx_data_i = 8'h3C;
        capture(-1, '0, '0, len, w, rl, ir, it);
        elen = model(8'hA5, 8'h03, 1, -1, ew);
        n_cmp++;
        if (len !== elen || w !== ew) begin
            n_bad++;
            $display("FAIL b2b_first: got %0d cycles (%0d differ) required %0d",
                     len, $countones(w ^ ew), elen);
        end
        n_cmp++;
        if ({ir, it} !== 2'b11) begin
            n_bad++;
            $display("FAIL b2b_gap: got rdy/txd=%b required 11", {ir, it});
        end
        @(posedge clk);
        #1;
        tx_valid_i = 1'b0;
        capture(-1, '0, '0, len, w, rl, ir, it);
        elen = model(8'h3C, 8'h03, 1, -1, ew);
        n_cmp++;
        if (len !== elen || w !== ew) begin
            n_bad++;
            $display("FAIL b2b_second: got %0d cycles (%0d differ) required %0d",
                     len, $countones(w ^ ew), elen);
        end
    endtask

    task automatic test_mid_change;
        int len, elen;
        logic [2047:0] w, ew;
        logic rl, ir, it;
        logic [7:0] d1, d2;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        divisor_i = 16'd2;
        lcr_i = 8'h03;
        start_frame(d1, 1'b0);
        capture(100, 16'd5, 8'h00, len, w, rl, ir, it);
        elen = model(d1, 8'h03, 2, -1, ew);
        n_cmp++;
        if (len !== elen || w !== ew) begin
            n_bad++;
            $display("FAIL chg_current: got %0d cycles (%0d differ) required %0d",
                     len, $countones(w ^ ew), elen);
        end
        start_frame(d2, 1'b0);
        capture(-1, '0, '0, len, w, rl, ir, it);
        elen = model(d2, 8'h00, 5, -1, ew);
        n_cmp++;
        if (len !== elen || w !== ew) begin
            n_bad++;
            $display("FAIL chg_next: got %0d cycles (%0d differ) required %0d",
                     len, $countones(w ^ ew), elen);
        end
    endtask

    task automatic test_break_reset;
        int len, elen;
        logic [2047:0] w, ew;
        logic rl, ir, it;
        divisor_i = 16'd1;
        lcr_i = 8'h03;
        start_frame(8'hFF, 1'b0);
        capture(50, 16'd1, 8'h43, len, w, rl, ir, it);
        elen = model(8'hFF, 8'h03, 1, 50, ew);
        n_cmp++;
        if (len !== elen || w !== ew) begin
            n_bad++;
            $display("FAIL break_wave: got %0d cycles (%0d differ) required %0d",
                     len, $countones(w ^ ew), elen);
        end
        n_cmp++;
        if ({ir, it} !== 2'b10) begin
            n_bad++;
            $display("FAIL break_idle: got rdy/txd=%b required 10", {ir, it});
        end
        lcr_i = 8'h03;
        start_frame(8'h00, 1'b0);
        repeat (40) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({txd_o, tx_busy_o, tx_ready_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL async_reset: got txd/busy/rdy=%b required 100",
                     {txd_o, tx_busy_o, tx_ready_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (tx_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rerelease_ready: got %b required 0", tx_ready_o);
        end
        @(negedge clk);
        n_cmp++;
        if ({txd_o, tx_busy_o, tx_ready_o} !== 3'b101) begin
            n_bad++;
            $display("FAIL rerelease_idle: got txd/busy/rdy=%b required 101",
                     {txd_o, tx_busy_o, tx_ready_o});
        end
    endtask

    task automatic test_random;
        int len, elen, d;
        logic [2047:0] w, ew;
        logic rl, ir, it;
        logic [7:0] lcr, data;
        for (int t = 0; t < 10; t++) begin
            d = int'($urandom_range(0, 4));
            lcr = 8'($urandom_range(0, 63));
            data = 8'($urandom);
            divisor_i = 16'(d);
            lcr_i = lcr;
            start_frame(data, 1'b0);
            capture(-1, '0, '0, len, w, rl, ir, it);
            elen = model(data, lcr, d, -1, ew);
            n_cmp++;
            if (len !== elen || w !== ew || {rl, ir, it} !== 3'b111) begin
                n_bad++;
                $display("FAIL rnd%0d d=%0d lcr=%h data=%h: got %0d cycles (%0d differ) hs=%b required %0d hs=111",
                         t, d, lcr, data, len, $countones(w ^ ew), {rl, ir, it}, elen);
            end
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_mid_change();
        test_break_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
